counter_run_ctrl: RTL and testbench



---
 rtl/counter_run_ctrl.sv | 133 +++++++++++++
 tb/tb_counter_run_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - command sequencer driving load/step strobes of the tt_um_counter core
// Optional COUNTER_RUN_CTRL_AUTO_RELOAD_EN: DONE reloads start_val instead of returning to IDLE.
module counter_run_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_step,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_SET_LIMIT = 2'd0;
  localparam logic [1:0] OP_SET_DIV   = 2'd1;
  localparam logic [1:0] OP_START     = 2'd2;
  localparam logic [1:0] OP_STOP      = 2'd3;

  state_t             cur;
  state_t             nxt;
  logic [WIDTH-1:0]   limit;
  logic [WIDTH-1:0]   start_val;
  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   presc;
  logic [DIV_W-1:0]   presc_nxt;
  logic               up;
  logic               go;
  logic               accept;
  logic               is_start;
  logic               is_stop;
  logic               step;

  always_comb begin
    go        = ena && rst_n;
    cmd_ready = go && (cur != LOAD);
    accept    = cmd_valid && cmd_ready;
    is_start  = accept && (cmd_op == OP_START);
    is_stop   = accept && (cmd_op == OP_STOP);
    nxt       = cur;
    presc_nxt = presc;
    step      = 1'b0;

    case (cur)
      IDLE: nxt = IDLE;
      LOAD: begin
        nxt       = RUN;
        presc_nxt = '0;
      end
      RUN: begin
        // terminal check beats the prescaler so the counter never overshoots the limit
        if (cnt_value == limit) begin
          nxt = DONE;
        end else if (presc == div) begin
          step      = 1'b1;
          presc_nxt = '0;
        end else begin
          presc_nxt = presc + DIV_W'(1);
        end
      end
      DONE: begin
`ifdef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
        nxt       = LOAD;
        presc_nxt = '0;
`else
        nxt       = IDLE;
`endif
      end
      default: nxt = IDLE;
    endcase

    if (is_start) begin
      nxt       = LOAD;
      presc_nxt = '0;
      step      = 1'b0;
    end else if (is_stop && cur != IDLE) begin
      nxt       = IDLE;
      presc_nxt = '0;
      step      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= IDLE;
      limit     <= '1;
      div       <= '0;
      presc     <= '0;
      start_val <= '0;
      up        <= 1'b0;
    end else if (ena) begin
      cur   <= nxt;
      presc <= presc_nxt;
      if (accept) begin
        case (cmd_op)
          OP_SET_LIMIT: limit <= cmd_arg;
          OP_SET_DIV:   div   <= cmd_arg[DIV_W-1:0];
          OP_START: begin
            start_val <= cmd_arg;
            up        <= (cmd_arg < limit);
          end
          default: ;
        endcase
      end
    end
  end

  // strobes are decodes of the state register, masked while frozen or in reset
  assign cnt_load     = go && (cur == LOAD);
  assign cnt_step     = go && step;
  assign done         = go && (cur == DONE);
  assign busy         = (cur == LOAD) || (cur == RUN);
  assign cnt_load_val = start_val;
  assign cnt_up       = up;
  assign state        = cur;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - self-checking bench for counter_run_ctrl with a tick-schedule model
// Also hosts a behavioural 4-bit counter core that follows the DUT strobes.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic [3:0] cnt_value = 4'd0;
  logic       cmd_ready, cnt_load, cnt_step, cnt_up, busy, done;
  logic [3:0] cnt_load_val;
  logic [1:0] state;

  counter_run_ctrl #(.WIDTH(4), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_value(cnt_value), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .cnt_step(cnt_step), .cnt_up(cnt_up), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // counter core: load wins over step, wraps modulo 16
  always @(posedge clk) begin
    if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_step) cnt_value <= cnt_up ? cnt_value + 4'd1 : cnt_value - 4'd1;
  end

  // model: a run is scheduled in active ticks relative to the tick after START
  int         m_T = 0;
  int         m_s = 0;
  int         m_d = 0;
  int         m_term = -1;
  logic       m_active = 1'b0;
  logic [3:0] m_a = 4'd0;
  logic       m_up = 1'b0;
  logic [3:0] m_limit = 4'hF;
  logic [3:0] m_div = 4'd0;
  logic       started = 1'b0;

  int         rel, k, dp, ph;
  logic [3:0] v;
  logic       go_m, acc_m, ss_m, term_m, e_ready, e_step, e_load, e_done, e_busy;

  always_comb begin
    rel = m_T - m_s;
    dp  = m_d + 1;
    k   = (rel >= 1) ? (rel - 1) / dp : 0;
    v   = m_up ? 4'(m_a + k) : 4'(m_a - k);
    if (!m_active) ph = 0;
    else if (rel == 0) ph = 1;
    else if (m_term >= 0 && m_T == m_term + 1) ph = 3;
    else ph = 2;
    go_m    = ena && rst_n;
    e_ready = go_m && ph != 1;
    acc_m   = cmd_valid && e_ready;
    ss_m    = acc_m && cmd_op[1];
    term_m  = ph == 2 && v == m_limit && !ss_m;
    e_step  = go_m && ph == 2 && !ss_m && v != m_limit && (rel % dp == 0);
    e_load  = go_m && ph == 1;
    e_done  = go_m && ph == 3;
    e_busy  = ph == 1 || ph == 2;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_limit  <= 4'hF;
      m_div    <= 4'd0;
      m_a      <= 4'd0;
      m_up     <= 1'b0;
      m_term   <= -1;
      started  <= 1'b1;
    end else if (ena) begin
      m_T <= m_T + 1;
      if (acc_m && cmd_op == 2'd0) m_limit <= cmd_arg;
      if (acc_m && cmd_op == 2'd1) m_div <= cmd_arg;
      if (acc_m && cmd_op == 2'd2) begin
        m_active <= 1'b1;
        m_s      <= m_T + 1;
        m_a      <= cmd_arg;
        m_up     <= cmd_arg < m_limit;
        m_d      <= int'(m_div);
        m_term   <= -1;
      end else if (acc_m && cmd_op == 2'd3) begin
        m_active <= 1'b0;
      end else if (term_m) begin
        m_term <= m_T;
      end else if (ph == 3) begin
`ifdef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
        m_s    <= m_T + 1;
        m_d    <= int'(m_div);
        m_term <= -1;
`else
        m_active <= 1'b0;
`endif
      end
    end
  end

  int cyc = 0;
  int step_cnt, done_cnt, load_cnt, last_step, gmin, gmax;
  logic [3:0] last_load_val;

  always @(negedge clk) begin
    cyc++;
    if (started) begin
      check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      check("state", 32'(state), ph);
      check("cnt_load", 32'(cnt_load), 32'(e_load));
      check("cnt_step", 32'(cnt_step), 32'(e_step));
      check("done", 32'(done), 32'(e_done));
      check("busy", 32'(busy), 32'(e_busy));
      check("cnt_up", 32'(cnt_up), 32'(m_up));
      if (e_load) check("cnt_load_val", 32'(cnt_load_val), 32'(m_a));
      if (ph == 2) check("cnt_value", 32'(cnt_value), 32'(v));
    end
    if (cnt_step) begin
      step_cnt++;
      if (last_step >= 0) begin
        if (cyc - last_step < gmin) gmin = cyc - last_step;
        if (cyc - last_step > gmax) gmax = cyc - last_step;
      end
      last_step = cyc;
    end
    if (done) done_cnt++;
    if (cnt_load) begin
      load_cnt++;
      last_load_val = cnt_load_val;
    end
  end

  task automatic clr();
    step_cnt = 0; done_cnt = 0; load_cnt = 0; last_step = -1; gmin = 1000; gmax = -1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] arg);
    logic got = 1'b0;
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(got), 1);
  endtask

  task automatic wait_idle(input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (state == 2'd0) begin ok = 1'b1; break; end
    end
    check("idle_reached", 32'(ok), 1);
  endtask

  task automatic wait_val(input logic [3:0] val);
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (state == 2'd2 && cnt_value == val) begin ok = 1'b1; break; end
    end
    check("value_reached", 32'(ok), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int frozen_steps;
    clr();
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 4'd3;
    @(posedge clk); #1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_ready", 32'(cmd_ready), 0);
      check("rst_state", 32'(state), 0);
      check("rst_strobes", {29'd0, cnt_load, cnt_step, done}, 0);
    end
    rst_n = 1'b1; cmd_valid = 1'b0;

    clr(); cmd(2'd2, 4'd0); wait_idle(100);
    check("default_steps", step_cnt, 15);
    check("default_done", done_cnt, 1);
    check("default_end_val", 32'(cnt_value), 15);

    cmd(2'd0, 4'd5); clr(); cmd(2'd2, 4'd2); wait_idle(100);
    check("up_loads", load_cnt, 1);
    check("up_load_val", 32'(last_load_val), 2);
    check("up_steps", step_cnt, 3);
    check("up_gap", gmax, 1);
    check("up_done", done_cnt, 1);
    check("up_dir", 32'(cnt_up), 1);

    cmd(2'd1, 4'd2); cmd(2'd0, 4'd1); clr(); cmd(2'd2, 4'd7); wait_idle(200);
    check("down_dir", 32'(cnt_up), 0);
    check("down_steps", step_cnt, 6);
    check("down_gap_min", gmin, 3);
    check("down_gap_max", gmax, 3);
    check("down_done", done_cnt, 1);
    check("down_end_val", 32'(cnt_value), 1);

    cmd(2'd1, 4'd0); cmd(2'd0, 4'd9); clr(); cmd(2'd2, 4'd9); wait_idle(20);
    check("zero_steps", step_cnt, 0);
    check("zero_done", done_cnt, 1);
    check("zero_loads", load_cnt, 1);

    cmd(2'd0, 4'd4); clr(); cmd(2'd2, 4'd2); wait_val(4'd4); cmd(2'd3, 4'd0);
    check("collide_state", 32'(state), 0);
    repeat (3) @(posedge clk);
    #1;
    check("collide_done", done_cnt, 0);
    check("collide_steps", step_cnt, 2);

    cmd(2'd0, 4'd10); clr(); cmd(2'd2, 4'd0); wait_val(4'd3); cmd(2'd2, 4'd8); wait_idle(100);
    check("restart_loads", load_cnt, 2);
    check("restart_load_val", 32'(last_load_val), 8);
    check("restart_steps", step_cnt, 5);
    check("restart_done", done_cnt, 1);
    check("restart_end_val", 32'(cnt_value), 10);

    cmd(2'd1, 4'd3); cmd(2'd0, 4'd12); clr(); cmd(2'd2, 4'd10);
    repeat (2) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    frozen_steps = step_cnt;
    ena = 1'b1;
    wait_idle(100);
    check("freeze_no_steps", frozen_steps, 0);
    check("freeze_steps", step_cnt, 2);
    check("freeze_gap", gmax, 4);
    check("freeze_done", done_cnt, 1);

    cmd(2'd1, 4'd1); cmd(2'd0, 4'd0); clr(); cmd(2'd2, 4'd5);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_state", 32'(state), 0);
    check("midrst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_done", done_cnt, 0);

    cmd(2'd0, 4'd6); clr(); cmd(2'd2, 4'd4); wait_val(4'd5); cmd(2'd0, 4'd2); wait_idle(100);
    check("wrap_steps", step_cnt, 14);
    check("wrap_done", done_cnt, 1);
    check("wrap_end_val", 32'(cnt_value), 2);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
